// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: core and loader request ports plus the shared memory port.
// slave = arbiter view, master = environment (requesters and memory) view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic [DW-1:0] c_rdata;
   logic          c_done;

   logic          l_req;
   logic          l_we;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;
   logic [DW-1:0] l_rdata;
   logic          l_done;

   logic          m_en;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_rdata, c_done,
      input  l_req, l_we, l_addr, l_wdata,
      output l_rdata, l_done,
      output m_en, m_we, m_addr, m_wdata,
      input  m_rdata
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_rdata, c_done,
      output l_req, l_we, l_addr, l_wdata,
      input  l_rdata, l_done,
      input  m_en, m_we, m_addr, m_wdata,
      output m_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared instruction/data memory port: IDLE -> ISSUE -> WAIT -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed loader priority.
module mem_port_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus,
   output logic              busy,
   output logic              owner
);

   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic [DW-1:0] c_rdata_q, l_rdata_q;
   logic          any_req;
   logic          grant_l;
   logic          m_en, m_we, c_done, l_done;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_l;  // 1 = loader was granted last; reset favours the loader next

   always_comb begin
      any_req = bus.c_req | bus.l_req;
      grant_l = bus.l_req & (~bus.c_req | ~last_l);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         last_l <= 1'b0;
      else if (state == IDLE && any_req)
         last_l <= grant_l;
   end
`else
   always_comb begin
      any_req = bus.c_req | bus.l_req;
      grant_l = bus.l_req;
   end
`endif

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      m_en      = 1'b0;
      m_we      = 1'b0;
      c_done    = 1'b0;
      l_done    = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req) state_nxt = ISSUE;
         end
         ISSUE: begin
            m_en      = 1'b1;
            m_we      = lat_we;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == CW'(1)) state_nxt = RESP;
         end
         RESP: begin
            c_done    = ~owner;
            l_done    = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
         c_rdata_q <= '0;
         l_rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               // Requester inputs are only sampled here; later changes are ignored.
               if (any_req) begin
                  owner     <= grant_l;
                  lat_we    <= grant_l ? bus.l_we    : bus.c_we;
                  lat_addr  <= grant_l ? bus.l_addr  : bus.c_addr;
                  lat_wdata <= grant_l ? bus.l_wdata : bus.c_wdata;
               end
            end
            ISSUE: cnt <= CW'(LAT);
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1) && !lat_we) begin
                  if (owner) l_rdata_q <= bus.m_rdata;
                  else       c_rdata_q <= bus.m_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.m_en    = m_en;
   assign bus.m_we    = m_we;
   assign bus.m_addr  = lat_addr;
   assign bus.m_wdata = lat_wdata;
   assign bus.c_done  = c_done;
   assign bus.l_done  = l_done;
   assign bus.c_rdata = c_rdata_q;
   assign bus.l_rdata = l_rdata_q;

endmodule
